// File: rtl/lcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_pkg : shared LCD constants, writer FSM encoding, RGB565 colours |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package lcd_pkg;

    localparam int WORD_W = 9;
    localparam int DC_BIT = 8;

    // One-hot writer state encoding
    localparam logic [5:0] ST_IDLE  = 6'b000001;
    localparam logic [5:0] ST_SETUP = 6'b000010;
    localparam logic [5:0] ST_SHIFT = 6'b000100;
    localparam logic [5:0] ST_HOLD  = 6'b001000;
    localparam logic [5:0] ST_DONE  = 6'b010000;
    localparam logic [5:0] ST_GAP   = 6'b100000;

    typedef enum logic [5:0] {
        S_IDLE  = ST_IDLE,
        S_SETUP = ST_SETUP,
        S_SHIFT = ST_SHIFT,
        S_HOLD  = ST_HOLD,
        S_DONE  = ST_DONE,
        S_GAP   = ST_GAP
    } lcd_state_t;

    localparam logic [7:0] CMD_CASET = 8'h2A;
    localparam logic [7:0] CMD_RASET = 8'h2B;
    localparam logic [7:0] CMD_RAMWR = 8'h2C;

    localparam logic [15:0] RGB565_BLACK = 16'h0000;
    localparam logic [15:0] RGB565_WHITE = 16'hFFFF;
    localparam logic [15:0] RGB565_RED   = 16'hF800;
    localparam logic [15:0] RGB565_GREEN = 16'h07E0;
    localparam logic [15:0] RGB565_BLUE  = 16'h001F;

endpackage
`default_nettype wire

// File: rtl/lcd_tick_gen.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_tick_gen : one-cycle tick every CLK_DIV clocks, clearable      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lcd_tick_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    output logic tick
);

    localparam int                 C_CNT_W = $clog2(CLK_DIV) + 1;
    localparam logic [C_CNT_W-1:0] C_LAST  = C_CNT_W'(CLK_DIV - 1);

    logic [C_CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == C_LAST);

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_cnt <= '0;
        end else if (clr || tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_spi_writer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lcd_spi_writer : 9-bit {dc,byte} word to 4-wire SPI (mode 0, MSB)  |
// | Option LCD_SPI_CS_KEEP_EN holds cs_n low between streamed words.   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module lcd_spi_writer
    import lcd_pkg::*;
#(
    parameter int CLK_DIV  = 2,
    parameter int IDLE_GAP = 2
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              en_write,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_done,
    output logic              busy,
    output logic              lcd_cs_n,
    output logic              lcd_dc,
    output logic              lcd_scl,
    output logic              lcd_sda
);

    localparam int                 C_GAP_W    = $clog2(IDLE_GAP);
    localparam logic [C_GAP_W-1:0] C_GAP_LAST = C_GAP_W'(IDLE_GAP - 1);

    lcd_state_t         r_state;
    lcd_state_t         w_state_next;
    logic               w_tick;
    logic               w_tick_clr;
    logic               w_last_bit;
    logic [7:0]         r_shift;
    logic [2:0]         r_bit_cnt;
    logic               r_phase;
    logic               r_dc;
    logic [C_GAP_W-1:0] r_gap_cnt;

    lcd_tick_gen #(
        .CLK_DIV   (CLK_DIV)
    ) u_tick (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .clr       (w_tick_clr),
        .tick      (w_tick)
    );

    assign w_last_bit = (r_bit_cnt == 3'd7);
    assign lcd_dc     = r_dc;

`ifdef LCD_SPI_CS_KEEP_EN
    // Set when the requester still has data pending at word end
    logic r_keep;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_keep <= 1'b0;
        end else begin
            case (r_state)
                S_DONE:  r_keep <= en_write;
                S_IDLE:  if (!en_write) r_keep <= 1'b0;
                S_SETUP: r_keep <= 1'b0;
                default: ;
            endcase
        end
    end
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_tick_clr   = 1'b0;
        wr_done      = 1'b0;
        busy         = 1'b1;
        lcd_cs_n     = 1'b1;
        lcd_scl      = 1'b0;
        lcd_sda      = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
`ifdef LCD_SPI_CS_KEEP_EN
                lcd_cs_n = ~r_keep;
`endif
                if (en_write) begin
                    w_state_next = S_SETUP;
                    w_tick_clr   = 1'b1;
                end
            end
            S_SETUP: begin
                lcd_cs_n = 1'b0;
                lcd_sda  = r_shift[7];
                if (w_tick) w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                lcd_cs_n = 1'b0;
                lcd_sda  = r_shift[7];
                lcd_scl  = r_phase;
                if (w_tick && r_phase && w_last_bit) w_state_next = S_HOLD;
            end
            S_HOLD: begin
                lcd_cs_n = 1'b0;
                lcd_sda  = r_shift[7];
                if (w_tick) w_state_next = S_DONE;
            end
            S_DONE: begin
                wr_done      = 1'b1;
`ifdef LCD_SPI_CS_KEEP_EN
                lcd_cs_n     = ~en_write;
`endif
                w_state_next = S_GAP;
            end
            S_GAP: begin
`ifdef LCD_SPI_CS_KEEP_EN
                lcd_cs_n = ~r_keep;
`endif
                if (r_gap_cnt == C_GAP_LAST) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // sda advances only when a high phase ends, so it is stable at each rising scl
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            r_shift   <= '0;
            r_bit_cnt <= '0;
            r_phase   <= 1'b0;
            r_dc      <= 1'b0;
            r_gap_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (en_write) begin
                        r_shift   <= wr_data[7:0];
                        r_dc      <= wr_data[DC_BIT];
                        r_bit_cnt <= '0;
                        r_phase   <= 1'b0;
                    end
                end
                S_SHIFT: begin
                    if (w_tick) begin
                        r_phase <= ~r_phase;
                        if (r_phase && !w_last_bit) begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                            r_shift   <= {r_shift[6:0], 1'b0};
                        end
                    end
                end
                S_DONE:  r_gap_cnt <= '0;
                S_GAP:   r_gap_cnt <= r_gap_cnt + 1'b1;
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_lcd_spi_writer.sv
`default_nettype none
// Directed bench: two writers (CLK_DIV=2 and CLK_DIV=1) checked by an SPI
// receiver model against a queue of expected words and acceptance edges.
module tb_lcd_spi_writer;

    localparam int CDIV0 = 2;
    localparam int CDIV1 = 1;
    localparam int GAP   = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en0, en1;
    logic [8:0] data0, data1;
    logic       done0, busy0, cs0, dc0, scl0, sda0;
    logic       done1, busy1, cs1, dc1, scl1, sda1;

    always #5 clk = ~clk;

    lcd_spi_writer #(.CLK_DIV(CDIV0), .IDLE_GAP(GAP)) dut0 (
        .sys_clk(clk), .sys_rst_n(rst_n), .en_write(en0), .wr_data(data0),
        .wr_done(done0), .busy(busy0), .lcd_cs_n(cs0), .lcd_dc(dc0),
        .lcd_scl(scl0), .lcd_sda(sda0)
    );

    lcd_spi_writer #(.CLK_DIV(CDIV1), .IDLE_GAP(GAP)) dut1 (
        .sys_clk(clk), .sys_rst_n(rst_n), .en_write(en1), .wr_data(data1),
        .wr_done(done1), .busy(busy1), .lcd_cs_n(cs1), .lcd_dc(dc1),
        .lcd_scl(scl1), .lcd_sda(sda1)
    );

    int         cyc = 0;
    int         n_assert = 0;
    int         n_fail = 0;
    logic [8:0] exp_q0[$];
    logic [8:0] exp_q1[$];
    int         k_q0[$];
    int         k_q1[$];
    int         cs_runs[$];
    int         cs_run = 0;
    int         done_cnt[2] = '{0, 0};
    int         nbits[2] = '{0, 0};
    int         last_rise[2] = '{0, 0};
    logic [7:0] rx[2] = '{8'h00, 8'h00};
    logic       prev_scl[2] = '{1'b0, 1'b0};
    logic       prev_cs[2] = '{1'b1, 1'b1};

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // SPI receiver model for writer i, evaluated once per cycle mid-period
    task automatic mon(input int i, input int cdiv, input logic rst, input logic en,
                       input logic scl, input logic sda, input logic dc, input logic cs,
                       input logic done, input logic busy);
        logic [8:0] fr;
        int         kf;
        bit         have;
        have = (i == 0) ? (exp_q0.size() > 0 && k_q0.size() > 0)
                        : (exp_q1.size() > 0 && k_q1.size() > 0);
        fr = '0;
        kf = 0;
        if (have) begin
            fr = (i == 0) ? exp_q0[0] : exp_q1[0];
            kf = (i == 0) ? k_q0[0] : k_q1[0];
        end
        if (!rst) begin
            nbits[i] = 0;
            if (i == 0) k_q0.delete(); else k_q1.delete();
        end else begin
            if (en && !busy) begin
                if (i == 0) k_q0.push_back(cyc + 1); else k_q1.push_back(cyc + 1);
            end
            if (scl && !prev_scl[i]) begin
                check($sformatf("u%0d_cs_at_rise", i), cs, 0);
                check($sformatf("u%0d_dc_at_rise", i), dc, fr[8]);
                if (nbits[i] == 0)
                    check($sformatf("u%0d_first_rise_time", i), cyc, kf + 2 * cdiv);
                else
                    check($sformatf("u%0d_bit_period", i), cyc - last_rise[i], 2 * cdiv);
                last_rise[i] = cyc;
                rx[i] = {rx[i][6:0], sda};
                nbits[i]++;
            end
            if (done) begin
                done_cnt[i]++;
                check($sformatf("u%0d_done_expected", i), have, 1);
                check($sformatf("u%0d_done_nbits", i), nbits[i], 8);
                check($sformatf("u%0d_done_byte", i), rx[i], fr[7:0]);
                check($sformatf("u%0d_done_latency", i), cyc, kf + 18 * cdiv);
`ifndef LCD_SPI_CS_KEEP_EN
                check($sformatf("u%0d_done_cs_rise", i), {prev_cs[i], cs}, 2'b01);
`endif
                nbits[i] = 0;
                if (have) begin
                    if (i == 0) begin
                        void'(exp_q0.pop_front()); void'(k_q0.pop_front());
                    end else begin
                        void'(exp_q1.pop_front()); void'(k_q1.pop_front());
                    end
                end
            end
        end
        if (i == 0) begin
            if (cs === 1'b1) cs_run++;
            else if (prev_cs[0] === 1'b1) begin
                cs_runs.push_back(cs_run);
                cs_run = 0;
            end
        end
        prev_scl[i] = scl;
        prev_cs[i]  = cs;
    endtask

    always @(negedge clk) begin
        mon(0, CDIV0, rst_n, en0, scl0, sda0, dc0, cs0, done0, busy0);
        mon(1, CDIV1, rst_n, en1, scl1, sda1, dc1, cs1, done1, busy1);
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input int i, input logic [8:0] w);
        int t;
        step(1);
        if (i == 0) begin exp_q0.push_back(w); en0 = 1'b1; data0 = w; end
        else        begin exp_q1.push_back(w); en1 = 1'b1; data1 = w; end
        t = 0;
        do begin @(negedge clk); t++; end
        while (!((i == 0) ? busy0 : busy1) && t < 20);
        check($sformatf("u%0d_accept", i), (i == 0) ? busy0 : busy1, 1);
        step(1);
        if (i == 0) en0 = 1'b0; else en1 = 1'b0;
    endtask

    task automatic wait_done(input int i);
        int t;
        t = 0;
        do begin @(negedge clk); t++; end
        while (!((i == 0) ? done0 : done1) && t < 200);
        check($sformatf("u%0d_wait_done", i), (i == 0) ? done0 : done1, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] w[3];
        int         base;
        int         t;
        w[0] = 9'h02A; w[1] = 9'h155; w[2] = 9'h1E0;
        rst_n = 1'b0; en0 = 1'b0; en1 = 1'b0; data0 = '0; data1 = '0;
        step(3);
        @(negedge clk);
        check("rst_cs_n", cs0, 1);
        check("rst_scl", scl0, 0);
        check("rst_sda", sda0, 0);
        check("rst_dc", dc0, 0);
        check("rst_wr_done", done0, 0);
        check("rst_busy", busy0, 0);
        check("rst_u1_cs_n", cs1, 1);
        check("rst_u1_busy", busy1, 0);
        step(1);
        rst_n = 1'b1;

        // RAMWR command, CLK_DIV=2
        start(0, 9'h02C);
        wait_done(0);

        // data word, CLK_DIV=1
        start(1, 9'h1A5);
        wait_done(1);

        // three streamed words with en_write held high
        step(4);
        cs_runs.delete();
        base = done_cnt[0];
        for (int j = 0; j < 3; j++) exp_q0.push_back(w[j]);
        en0 = 1'b1;
        data0 = w[0];
        for (int j = 0; j < 3; j++) begin
            wait_done(0);
            step(2);
            if (j < 2) data0 = w[j + 1];
            else       en0 = 1'b0;
        end
        step(60);
        check("stream_done_count", done_cnt[0] - base, 3);
        check("stream_queue_empty", exp_q0.size(), 0);
`ifdef LCD_SPI_CS_KEEP_EN
        check("stream_cs_falls", cs_runs.size(), 1);
`else
        check("stream_cs_falls", cs_runs.size(), 3);
        check("stream_gap_run_1", cs_runs[1], 1 + GAP + 1);
        check("stream_gap_run_2", cs_runs[2], 1 + GAP + 1);
`endif

        // reset during bit 4
        step(4);
        start(0, 9'h0F0);
        t = 0;
        do begin @(negedge clk); t++; end while (nbits[0] < 4 && t < 100);
        check("abort_reached_bit4", nbits[0], 4);
        base = done_cnt[0];
        step(1);
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        exp_q0.delete();
        @(negedge clk);
        check("abort_cs_n", cs0, 1);
        check("abort_scl", scl0, 0);
        check("abort_busy", busy0, 0);
        check("abort_wr_done", done0, 0);
        step(60);
        check("abort_no_done", done_cnt[0] - base, 0);

        start(0, 9'h1C3);
        wait_done(0);
        step(3);
        check("dc_hold_1", dc0, 1);
        check("idle_sda", sda0, 0);
        check("idle_cs_n", cs0, 1);

        // wr_data changes mid-shift; the latched byte must go out
        start(0, 9'h081);
        step(10);
        data0 = 9'h17E;
        wait_done(0);
        step(3);
        check("dc_hold_0", dc0, 0);
        check("idle_busy", busy0, 0);
        check("final_q0_empty", exp_q0.size(), 0);
        check("final_q1_empty", exp_q1.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
